// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin, one BLOCK_W-bit block per clock, LSB block first.
// Optional signed overflow flag is built only when SUB_OVERFLOW_EN is defined.
module block_serial_subtractor #(
    parameter int N_BLOCKS = 4,
    parameter int BLOCK_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_BLOCKS*BLOCK_W-1:0]   a,
    input  logic [N_BLOCKS*BLOCK_W-1:0]   b,
    input  logic                          bin,
    output logic                          busy,
    output logic                          done,
    output logic [N_BLOCKS*BLOCK_W-1:0]   diff,
    output logic                          bout,
    output logic                          zero,
    output logic                          ovf
);
    // state  | meaning
    // S_IDLE | waiting for start, results held
    // S_BUSY | one block per cycle, borrow carried in br
    // S_DONE | done pulse; a start here is accepted back-to-back

    localparam int W     = N_BLOCKS * BLOCK_W;
    localparam int IDX_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BLOCKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [IDX_W-1:0]   idx;
    logic               br;

    logic [BLOCK_W-1:0] a_blk;
    logic [BLOCK_W-1:0] b_blk;
    logic [BLOCK_W-1:0] g;
    logic [BLOCK_W-1:0] p;
    logic [BLOCK_W-1:0] d_blk;
    logic [BLOCK_W:0]   bw;
    logic [W-1:0]       diff_nxt;
    logic               run_p;
    logic               acc;

    // Borrow into bit i+1 expanded as g_i | p_i g_(i-1) | ... | p_i..p_0 br.
    always_comb begin
        run_p    = 1'b0;
        acc      = 1'b0;
        bw       = '0;
        a_blk    = a_r[idx*BLOCK_W +: BLOCK_W];
        b_blk    = b_r[idx*BLOCK_W +: BLOCK_W];
        g        = ~a_blk & b_blk;
        p        = ~(a_blk ^ b_blk);
        bw[0]    = br;
        for (int i = 0; i < BLOCK_W; i++) begin
            run_p = 1'b1;
            acc   = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                run_p = run_p & p[j+1];
                acc   = acc | (g[j] & run_p);
            end
            acc       = acc | (run_p & p[0] & br);
            bw[i+1]   = acc;
        end
        d_blk    = ~p ^ bw[BLOCK_W-1:0];
        diff_nxt = diff;
        diff_nxt[idx*BLOCK_W +: BLOCK_W] = d_blk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        br    <= bin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_BUSY;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    diff <= diff_nxt;
                    br   <= bw[BLOCK_W];
                    if (idx == LAST) begin
                        bout  <= bw[BLOCK_W];
                        zero  <= ~|diff_nxt;
`ifdef SUB_OVERFLOW_EN
                        ovf   <= (a_r[W-1] ^ b_r[W-1]) & (a_r[W-1] ^ diff_nxt[W-1]);
`endif
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef SUB_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Self-checking bench for block_serial_subtractor (32-bit default build; honours SUB_OVERFLOW_EN).
module tb_block_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    block_serial_subtractor #(.N_BLOCKS(4), .BLOCK_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf_en;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole 32-bit operands.
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                                  output logic [31:0] d, output logic bo, output logic z,
                                  output logic o);
        longint ua = ta;
        longint ub = tb_;
        longint bi = tbin;
        longint sa = $signed(ta);
        longint sb = $signed(tb_);
        longint r  = ua - ub - bi;
        longint rs = sa - sb - bi;
        d  = r[31:0];
        bo = (r < 0);
        z  = (d == 32'd0);
`ifdef SUB_OVERFLOW_EN
        o  = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
`else
        o  = 1'b0;
`endif
    endfunction

    function automatic logic exp_ovf(input logic v);
`ifdef SUB_OVERFLOW_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string nm, input logic [31:0] ed, input logic eb,
                                input logic ez, input logic eo);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
        chk({nm, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
    endtask

    vec_t vecs[10];

    initial begin
        int          lat;
        logic [31:0] ed;
        logic        eb, ez, eo;
        int          last_done, n_done, overlap;
        logic [31:0] pa, pb;
        logic        pbin;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        check_result("rst", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].bin);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_done(0, lat);
            chk($sformatf("v%0d_lat", i), lat, 4);
            check_result($sformatf("v%0d", i), vecs[i].diff, vecs[i].bout, vecs[i].zero,
                         exp_ovf(vecs[i].ovf_en));
            chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check_result($sformatf("v%0d_hold", i), vecs[i].diff, vecs[i].bout, vecs[i].zero,
                         exp_ovf(vecs[i].ovf_en));
        end

        // Start during BUSY must be ignored
        launch(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        @(posedge clk); #1;
        a = 32'h0000_0001; b = 32'h1111_1111; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, lat);
        chk("ign_lat", lat, 4);
        model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, ed, eb, ez, eo);
        check_result("ign", ed, eb, ez, eo);
        @(posedge clk); #1;
        chk("ign_idle_busy", {31'd0, busy}, 32'd0);

        // Start held high: back-to-back results every 5 cycles; garbage on a/b while busy
        pa = $urandom; pb = $urandom; pbin = 1'($urandom_range(1));
        @(negedge clk);
        a = pa; b = pb; bin = pbin; start = 1'b1;
        last_done = -1; n_done = 0; overlap = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (done && busy) overlap++;
            if (done) begin
                model(pa, pb, pbin, ed, eb, ez, eo);
                check_result($sformatf("held%0d", n_done), ed, eb, ez, eo);
                if (last_done >= 0) chk("held_period", cyc - last_done, 5);
                last_done = cyc;
                n_done++;
                if (cyc >= 24) begin
                    start = 1'b0;
                end else begin
                    pa = $urandom; pb = $urandom; pbin = 1'($urandom_range(1));
                    a = pa; b = pb; bin = pbin;
                end
            end else if (start) begin
                a = $urandom; b = $urandom; bin = 1'($urandom_range(1));
            end
        end
        chk("held_count", n_done, 5);
        chk("held_overlap", overlap, 0);

        // Reset two cycles into BUSY
        launch(32'h0000_0009, 32'h0000_0002, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        check_result("abort", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(32'h0000_0100, 32'h0000_0000, 1'b1);
        wait_done(0, lat);
        chk("post_rst_lat", lat, 4);
        check_result("post_rst", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            pa = $urandom;
            case ($urandom_range(3))
                0:       pb = pa;
                1:       pb = pa + 32'd1;
                2:       pb = {$urandom_range(1) ? 1'b1 : 1'b0, 31'($urandom)};
                default: pb = $urandom;
            endcase
            pbin = 1'($urandom_range(1));
            launch(pa, pb, pbin);
            wait_done(0, lat);
            chk($sformatf("rnd%0d_lat", i), lat, 4);
            model(pa, pb, pbin, ed, eb, ez, eo);
            check_result($sformatf("rnd%0d", i), ed, eb, ez, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
